dot_fp_seq: RTL

- Sequences a single shared minifloat multiplier (mul_fp6) over one MX block of element pairs and accumulates the exact fixed-point products into a wide signed sum.
- Input is one element pair per handshake; output is one sum per block_size pairs.
- Sits between the MX block unpacker and the shared-scale application stage. The caller applies the block scales afterwards.

---
 rtl/dot_fp_seq.sv | 138 +++++++++++++
 1 files changed

// File: rtl/dot_fp_seq.sv
// Minifloat dot-product sequencer: one shared exact multiplier feeding a
// wide fixed-point accumulator, one sum per block of element pairs.

module mul_fp6 #(
    parameter int exp_width = 5,
    parameter int man_width = 2,
    parameter int bit_width = 1 + exp_width + man_width,
    parameter int prd_width = 2 * ((1 << exp_width) + man_width + 2)
) (
    input  logic [bit_width-1:0]        i_op0,
    input  logic [bit_width-1:0]        i_op1,
    output logic signed [prd_width-1:0] o_prd
);

    localparam int mag_width = prd_width / 2;

    logic [exp_width-1:0] exp0, exp1;
    logic [exp_width-1:0] sh0, sh1;
    logic [mag_width-1:0] mag0, mag1;
    logic [prd_width-1:0] mag_p;

    // Magnitudes in units of the minimum subnormal; exponent 0 has no hidden bit
    always_comb begin
        exp0 = i_op0[bit_width-2 -: exp_width];
        exp1 = i_op1[bit_width-2 -: exp_width];
        sh0  = (exp0 == '0) ? '0 : exp0 - exp_width'(1);
        sh1  = (exp1 == '0) ? '0 : exp1 - exp_width'(1);
        mag0 = {{(mag_width-man_width-1){1'b0}}, (exp0 != '0),
                i_op0[man_width-1:0]} << sh0;
        mag1 = {{(mag_width-man_width-1){1'b0}}, (exp1 != '0),
                i_op1[man_width-1:0]} << sh1;
        mag_p = {{mag_width{1'b0}}, mag0} * {{mag_width{1'b0}}, mag1};
        if (i_op0[bit_width-1] ^ i_op1[bit_width-1])
            o_prd = $signed(-mag_p);
        else
            o_prd = $signed(mag_p);
    end

endmodule

module dot_fp_seq #(
    parameter int exp_width  = 5,
    parameter int man_width  = 2,
    parameter int block_size = 32,
    parameter int bit_width  = 1 + exp_width + man_width,
    parameter int prd_width  = 2 * ((1 << exp_width) + man_width + 2),
    parameter int acc_width  = prd_width + $clog2(block_size)
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic [bit_width-1:0]        i_op0,
    input  logic [bit_width-1:0]        i_op1,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic signed [acc_width-1:0] o_sum,
    output logic                        o_busy
);

    localparam int cnt_width = $clog2(block_size);
    localparam logic [cnt_width-1:0] cnt_last = cnt_width'(block_size - 1);

    typedef enum logic [1:0] {
        ST_ACC,
        ST_DRAIN,
        ST_OUT
    } state_t;

    state_t state, state_nxt;

    logic [cnt_width-1:0]        count;
    logic signed [prd_width-1:0] prd;
    logic signed [prd_width-1:0] prd_q;
    logic                        prd_vld;
    logic signed [acc_width-1:0] acc;
    logic                        accept;
    logic                        last;

    mul_fp6 #(
        .exp_width(exp_width),
        .man_width(man_width),
        .bit_width(bit_width),
        .prd_width(prd_width)
    ) u_mul (
        .i_op0(i_op0),
        .i_op1(i_op1),
        .o_prd(prd)
    );

    assign accept = i_valid && o_ready;
    assign last   = accept && (count == cnt_last);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            state <= ST_ACC;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_ACC:   if (last) state_nxt = ST_DRAIN;
            ST_DRAIN: state_nxt = ST_OUT;
            ST_OUT:   if (i_ready) state_nxt = ST_ACC;
            default:  state_nxt = ST_ACC;
        endcase
    end

    always_comb begin
        o_ready = (state == ST_ACC);
        o_valid = (state == ST_OUT);
        o_busy  = (count != '0) || (state != ST_ACC) || prd_vld;
        o_sum   = acc;
    end

    // The drain cycle exists so the last registered product lands in acc
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            count   <= '0;
            prd_q   <= '0;
            prd_vld <= 1'b0;
            acc     <= '0;
        end else begin
            prd_vld <= accept;
            if (accept) begin
                prd_q <= prd;
                count <= last ? '0 : count + cnt_width'(1);
            end
            if (state == ST_OUT && i_ready)
                acc <= '0;
            else if (prd_vld)
                acc <= acc + acc_width'(prd_q);
        end
    end

endmodule
